// File: rtl/mips16_pkg.sv
// Shared constants and bundle widths for the mips16 core slice.
// Owner encoding, data-memory geometry and request-bundle layout.
package mips16_pkg;

    localparam logic OWNER_CPU  = 1'b0;
    localparam logic OWNER_HOST = 1'b1;

    localparam int DMEM_ADDR_W = 6;
    localparam int DATA_W      = 16;

    localparam int MEM_REQ_WE_W    = 1;
    localparam int MEM_REQ_ADDR_W  = DMEM_ADDR_W;
    localparam int MEM_REQ_WDATA_W = DATA_W;
    localparam int MEM_REQ_W =
        MEM_REQ_WE_W + MEM_REQ_ADDR_W + MEM_REQ_WDATA_W;

    localparam int STARVE_CNT_W = 4;

    typedef struct packed {
        logic                   we;
        logic [DMEM_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]      wdata;
    } mem_req_t;

    function automatic mem_req_t mem_req_idle();
        return '0;
    endfunction

endpackage

// File: rtl/starve_counter.sv
// Saturating host-denial counter; at_max forces a host slot.
// Clear wins over increment so a grant always restarts the count.
module starve_counter
    import mips16_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam logic [STARVE_CNT_W-1:0] MAX =
        STARVE_CNT_W'(STARVE_MAX);

    logic [STARVE_CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && cnt != MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign at_max = (cnt == MAX);

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: CPU has fixed priority, host is guaranteed a
// slot after STARVE_MAX denials; reads return one cycle after grant.
module dmem_arbiter #(
    parameter int ADDR_W     = mips16_pkg::DMEM_ADDR_W,
    parameter int DATA_W     = mips16_pkg::DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic at_max;
    logic rd_pend;
    logic rd_owner;

    starve_counter #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve (
        .clk   (clk),
        .rst   (rst),
        .inc   (host_req & ~host_gnt),
        .clr   (host_gnt | ~host_req),
        .at_max(at_max)
    );

    always_comb begin
        host_gnt  = ~rst & host_req & (~cpu_req | at_max);
        cpu_gnt   = ~rst & cpu_req & ~host_gnt;
        cpu_stall = ~rst & cpu_req & ~cpu_gnt;
    end

    always_comb begin
        mem_en    = cpu_gnt | host_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (host_gnt) begin
            mem_we    = host_we;
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end else if (cpu_gnt) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend  <= 1'b0;
            rd_owner <= mips16_pkg::OWNER_CPU;
        end else begin
            rd_pend  <= mem_en & ~mem_we;
            rd_owner <= host_gnt ? mips16_pkg::OWNER_HOST
                                 : mips16_pkg::OWNER_CPU;
        end
    end

    // Gate on rst so a read granted just before reset never surfaces.
    always_comb begin
        cpu_rvalid  = ~rst & rd_pend & (rd_owner == mips16_pkg::OWNER_CPU);
        host_rvalid = ~rst & rd_pend & (rd_owner == mips16_pkg::OWNER_HOST);
        cpu_rdata   = cpu_rvalid  ? mem_rdata : '0;
        host_rdata  = host_rvalid ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a synchronous-read RAM model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [5:0]  cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_gnt, cpu_stall, cpu_rvalid;
    logic [15:0] cpu_rdata;
    logic        host_req, host_we;
    logic [5:0]  host_addr;
    logic [15:0] host_wdata;
    logic        host_gnt, host_rvalid;
    logic [15:0] host_rdata;
    logic        mem_en, mem_we;
    logic [5:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    logic [15:0] ram [64];

    typedef struct {
        logic        owner;
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    dmem_arbiter #(
        .ADDR_W(6), .DATA_W(16), .STARVE_MAX(4)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .host_req(host_req), .host_we(host_we),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid),
        .host_rdata(host_rdata),
        .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rst) begin
            ram[1]    <= 16'h1111;
            ram[2]    <= 16'h2222;
            mem_rdata <= 16'h0;
        end else if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr];
        end
    end

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
    endtask

    task automatic cpu_drive(input logic we, input logic [5:0] a,
                             input logic [15:0] d);
        cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic host_drive(input logic we, input logic [5:0] a,
                              input logic [15:0] d);
        host_req = 1; host_we = we; host_addr = a; host_wdata = d;
    endtask

    task automatic push(input logic owner, input logic [15:0] d);
        q.push_back('{owner: owner, data: d, due: cyc + 1});
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, " cpu_gnt"}, 32'(cpu_gnt), 0);
        chk({nm, " host_gnt"}, 32'(host_gnt), 0);
        chk({nm, " cpu_stall"}, 32'(cpu_stall), 0);
        chk({nm, " mem_en"}, 32'(mem_en), 0);
        chk({nm, " mem_we"}, 32'(mem_we), 0);
        chk({nm, " mem_addr"}, 32'(mem_addr), 0);
        chk({nm, " mem_wdata"}, 32'(mem_wdata), 0);
        chk({nm, " cpu_rvalid"}, 32'(cpu_rvalid), 0);
        chk({nm, " host_rvalid"}, 32'(host_rvalid), 0);
        chk({nm, " cpu_rdata"}, 32'(cpu_rdata), 0);
        chk({nm, " host_rdata"}, 32'(host_rdata), 0);
    endtask

    // Monitor: pops the scoreboard whenever a read response appears.
    always @(negedge clk) begin
        exp_t e;
        if (cpu_rvalid || host_rvalid) begin
            if (q.size() == 0) begin
                chk("unexpected rvalid", 32'({cpu_rvalid, host_rvalid}), 0);
            end else begin
                e = q.pop_front();
                chk("rvalid owner", 32'(host_rvalid), 32'(e.owner));
                chk("rvalid both", 32'(cpu_rvalid & host_rvalid), 0);
                chk("rvalid cycle", 32'(cyc), 32'(e.due));
                if (e.owner) begin
                    chk("host_rdata", 32'(host_rdata), 32'(e.data));
                    chk("idle cpu_rdata", 32'(cpu_rdata), 0);
                end else begin
                    chk("cpu_rdata", 32'(cpu_rdata), 32'(e.data));
                    chk("idle host_rdata", 32'(host_rdata), 0);
                end
            end
        end else if (q.size() != 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            chk("missing rvalid at cycle", 32'(cyc), 32'(e.due - 1));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic hg;
        rst = 1;
        idle();
        repeat (2) tick();
        cpu_drive(0, 1, 0);
        #1;
        chk_quiet("in reset");
        chk("reset starve_cnt", 32'(dut.u_starve.cnt), 0);

        tick();
        rst = 0;
        idle();
        #1;
        chk_quiet("after reset");

        // CPU write then read
        tick();
        cpu_drive(1, 5, 16'h00AA);
        #1;
        chk("cpu wr gnt", 32'(cpu_gnt), 1);
        chk("cpu wr mem_we", 32'(mem_we), 1);
        chk("cpu wr mem_addr", 32'(mem_addr), 5);
        chk("cpu wr mem_wdata", 32'(mem_wdata), 32'h00AA);
        tick();
        cpu_drive(0, 5, 0);
        #1;
        chk("cpu rd gnt", 32'(cpu_gnt), 1);
        chk("cpu rd mem_we", 32'(mem_we), 0);
        push(0, 16'h00AA);
        tick();
        idle();

        // Host write then read
        tick();
        host_drive(1, 63, 16'hBEEF);
        #1;
        chk("host wr gnt", 32'(host_gnt), 1);
        chk("host wr mem_addr", 32'(mem_addr), 63);
        chk("host wr mem_wdata", 32'(mem_wdata), 32'hBEEF);
        tick();
        host_drive(0, 63, 0);
        #1;
        chk("host rd gnt", 32'(host_gnt), 1);
        push(1, 16'hBEEF);
        tick();
        idle();

        // Alternating owners on consecutive reads
        tick();
        cpu_drive(0, 1, 0);
        #1;
        chk("alt cpu gnt", 32'(cpu_gnt), 1);
        push(0, 16'h1111);
        tick();
        cpu_req = 0;
        host_drive(0, 2, 0);
        #1;
        chk("alt host gnt", 32'(host_gnt), 1);
        push(1, 16'h2222);
        tick();
        host_req = 0;
        cpu_drive(0, 1, 0);
        #1;
        chk("alt cpu gnt 2", 32'(cpu_gnt), 1);
        push(0, 16'h1111);
        tick();
        idle();

        // Continuous contention: host wins every 5th cycle
        tick();
        cpu_drive(0, 1, 0);
        host_drive(0, 2, 0);
        for (int k = 1; k <= 15; k++) begin
            #1;
            hg = (k % 5 == 0);
            chk($sformatf("starve host_gnt k=%0d", k), 32'(host_gnt), 32'(hg));
            chk($sformatf("starve cpu_stall k=%0d", k), 32'(cpu_stall), 32'(hg));
            chk($sformatf("starve cpu_gnt k=%0d", k), 32'(cpu_gnt), 32'(!hg));
            if (hg) push(1, 16'h2222);
            else    push(0, 16'h1111);
            tick();
        end
        idle();

        // Host withdraws for one cycle: count restarts
        tick();
        cpu_drive(0, 1, 0);
        for (int k = 1; k <= 9; k++) begin
            if (k == 4) host_req = 0;
            else        host_drive(0, 2, 0);
            #1;
            hg = (k == 9);
            chk($sformatf("withdraw host_gnt k=%0d", k), 32'(host_gnt), 32'(hg));
            if (hg) push(1, 16'h2222);
            else    push(0, 16'h1111);
            tick();
        end
        idle();

        // Reset arrives the cycle after a granted CPU read
        tick();
        cpu_drive(0, 1, 0);
        host_drive(0, 2, 0);
        #1;
        chk("pre-reset cpu gnt", 32'(cpu_gnt), 1);
        tick();
        rst = 1;
        #1;
        chk_quiet("mid-read reset");
        tick();
        #1;
        chk_quiet("mid-read reset 2");
        chk("mid-read starve_cnt", 32'(dut.u_starve.cnt), 0);
        tick();
        rst = 0;
        idle();
        #1;
        chk_quiet("after mid-read reset");

        tick();
        tick();
        chk("scoreboard drained", 32'(q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the CPU's 64 x 16 data memory between the core's load/store path and a host (debug/loader) port. The CPU has fixed priority. A starvation counter guarantees the host a slot after `STARVE_MAX` consecutive denied cycles. The block sits between `mips_single_cycle`'s memory stage and a synchronous-read data RAM, returns read data one cycle after grant, and reports which requester owns each returning read.

## Interface
- `ADDR_W`, 6: memory address width (64 words).
- `DATA_W`, 16: data word width.
- `STARVE_MAX`, 4: consecutive host denials before a forced host grant; legal range 1..15.

Clock and reset: `clk`, rising edge; reset `rst`, synchronous, active-high.

- `clk  in  1`  clock
- `rst  in  1`  synchronous active-high reset
- `cpu_req  in  1`  CPU access request
- `cpu_we  in  1`  CPU write (1) / read (0)
- `cpu_addr  in  ADDR_W`  CPU word address
- `cpu_wdata  in  DATA_W`  CPU write data
- `cpu_gnt  out  1`  CPU granted this cycle (combinational)
- `cpu_stall  out  1`  `cpu_req & ~cpu_gnt`
- `cpu_rvalid  out  1`  CPU read data valid
- `cpu_rdata  out  DATA_W`  CPU read data
- `host_req  in  1`  host access request
- `host_we  in  1`  host write / read
- `host_addr  in  ADDR_W`  host word address
- `host_wdata  in  DATA_W`  host write data
- `host_gnt  out  1`  host granted this cycle (combinational)
- `host_rvalid  out  1`  host read data valid
- `host_rdata  out  DATA_W`  host read data
- `mem_en  out  1`  RAM access enable
- `mem_we  out  1`  RAM write enable
- `mem_addr  out  ADDR_W`  RAM address
- `mem_wdata  out  DATA_W`  RAM write data
- `mem_rdata  in  DATA_W`  RAM read data, valid the cycle after `mem_en & ~mem_we`

## Operation
- Grant rule, evaluated combinationally each cycle:
  - `host_gnt = host_req & (~cpu_req | starve_cnt == STARVE_MAX)`.
  - `cpu_gnt = cpu_req & ~host_gnt`.
  - At most one grant per cycle. Both grants are 0 while `rst` is high.
- Muxing: `mem_en = cpu_gnt | host_gnt`. `mem_we`, `mem_addr` and `mem_wdata` come from the granted port. With no grant, `mem_we`, `mem_addr` and `mem_wdata` are 0.
- Handshake: a requester holds `req`, `we`, `addr` and `wdata` stable until it sees `gnt`. Each grant is one transfer. A requester may drop `req` without penalty before it is granted.
- Starvation counter `starve_cnt`, 4-bit register:
  - Increments when `host_req & ~host_gnt`.
  - Clears to 0 on `host_gnt` or when `host_req` is low.
  - Never exceeds `STARVE_MAX`.
- Read return pipeline:
  - Registers `rd_pend` and `rd_owner` (0 = CPU, 1 = host) capture `mem_en & ~mem_we` and the winner.
  - Next cycle, `cpu_rvalid = rd_pend & ~rd_owner`, `host_rvalid = rd_pend & rd_owner`.
  - The selected `*_rdata` equals `mem_rdata`; the other port's `*_rdata` is 0.
- Writes produce no response; the grant is the completion.

## Timing
- Reset values: `starve_cnt=0`, `rd_pend=0`, `rd_owner=0`. All outputs 0 during and on the first cycle after reset.
- Grant latency: 0 cycles, same cycle as the request when the requester wins. Read latency: 1 cycle from grant to `rvalid`.
- Back-to-back: a grant is allowed every cycle. Reads on consecutive cycles give `rvalid` on consecutive cycles; owners may alternate.
- Worst-case host wait with continuous `cpu_req`: `STARVE_MAX` denied cycles, then a grant on cycle `STARVE_MAX+1`. During that forced cycle the CPU stalls (`cpu_stall=1`).
- Simultaneous requests to the same address: only the winner accesses. No merging or forwarding.
- Reset mid-operation: a read granted in the cycle before reset asserts never produces `rvalid`, because `rd_pend` is cleared.
- `STARVE_MAX=1`: with continuous requests from both ports, grants alternate CPU, host, CPU, host, and so on.

## Structure
- Shared package `mips16_pkg`:
  - `OWNER_CPU`/`OWNER_HOST` constants.
  - Default `DMEM_ADDR_W=6` and `DATA_W=16`.
  - A `mem_req_t`-style bundle constant set: field widths for `we`, `addr`, `wdata`.
- One natural sub-module, `starve_counter`: a saturating counter with `inc`/`clr` inputs and an `at_max` output, parameterised by `STARVE_MAX`.
- Grant logic, the mux and the read-return registers stay in the top.

## Test plan
- CPU only: `cpu_req` write addr 5 data 0x00AA, then read addr 5. Required: `cpu_gnt=1` both cycles, `cpu_rvalid=1` with `cpu_rdata=0x00AA` one cycle after the read grant, `host_rvalid=0`.
- Host only, with `cpu_req=0`: host write addr 63 data 0xBEEF, then read. Required: `host_gnt` immediate, `host_rdata=0xBEEF` one cycle later.
- Starvation with `STARVE_MAX=4`: `cpu_req` and `host_req` held high continuously. Required: `host_gnt` on cycles 5, 10, 15, …, with `cpu_stall=1` on exactly those cycles.
- Alternating reads: CPU reads addr 1 (0x1111) and host reads addr 2 (0x2222) on consecutive granted cycles. Required: `cpu_rvalid`/0x1111 then `host_rvalid`/0x2222 on consecutive cycles; the other port's `rdata` stays 0.
- Reset mid-read: a CPU read is granted and `rst` is asserted the next cycle. Required: `cpu_rvalid` stays 0, `starve_cnt=0`, and all outputs are 0 until `rst` deasserts.
- Host withdraws: `host_req` high for 3 denied cycles, then low for 1 cycle, then high again with the CPU still requesting. Required: the counter restarts and the host grant arrives 4 denied cycles later.
